// File: rtl/dreg_pipeline_pkg.sv
// dreg_pipeline_pkg -- shared constants and helpers for the dreg_pipeline slice.
//   DREG_WIDTH_DEF / DREG_DEPTH_DEF : default data width and stage count.
//   clog2()                         : ceiling log2, used to size the count port.
package dreg_pipeline_pkg;

    localparam int DREG_WIDTH_DEF = 8;
    localparam int DREG_DEPTH_DEF = 4;

    // Ceiling log2. Callers pass DEPTH+1 (always >= 2), so the result is >= 1.
    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r++;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/dreg_stage.sv
// dreg_stage -- one pipeline stage: a WIDTH-bit data register plus its valid bit.
// Ports:
//   clk, rstb      : clock, asynchronous active-low reset (clears data and valid)
//   en             : load d/d_valid on the rising edge
//   flush          : clear valid (data is kept); wins over en
//   d, d_valid     : incoming word and its qualifier
//   q, q_valid     : registered stage contents
module dreg_stage #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rstb,
    input  logic             en,
    input  logic             flush,
    input  logic [WIDTH-1:0] d,
    input  logic             d_valid,
    output logic [WIDTH-1:0] q,
    output logic             q_valid
);

    logic [WIDTH-1:0] data_q;
    logic             vld_q;

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            data_q <= '0;
            vld_q  <= 1'b0;
        end else if (flush) begin
            // Only the valid bit is invalidated; stale data stays in place.
            vld_q  <= 1'b0;
        end else if (en) begin
            data_q <= d;
            vld_q  <= d_valid;
        end
    end

    assign q       = data_q;
    assign q_valid = vld_q;

endmodule

// File: rtl/dreg_pipeline.sv
// dreg_pipeline -- DEPTH-stage enabled data pipeline with valid tracking and
// a registered occupancy count.
// Ports:
//   clk, rstb      : clock, asynchronous active-low reset
//   en             : advance all stages; 0 holds everything
//   flush          : synchronous invalidate of all stages (regardless of en)
//   d, d_valid     : word into stage 0
//   q, q_valid     : last stage contents (direct register outputs)
//   count          : number of valid stages, 0..DEPTH
//   taps, tap_valid: all stage contents, present only with DREG_PIPELINE_TAPS_EN
//                    (stage i at taps[i*WIDTH +: WIDTH], tap_valid[i])
module dreg_pipeline
    import dreg_pipeline_pkg::*;
#(
    parameter int WIDTH = DREG_WIDTH_DEF,
    parameter int DEPTH = DREG_DEPTH_DEF
) (
    input  logic                        clk,
    input  logic                        rstb,
    input  logic                        en,
    input  logic                        flush,
    input  logic [WIDTH-1:0]            d,
    input  logic                        d_valid,
    output logic [WIDTH-1:0]            q,
    output logic                        q_valid,
`ifdef DREG_PIPELINE_TAPS_EN
    output logic [WIDTH*DEPTH-1:0]      taps,
    output logic [DEPTH-1:0]            tap_valid,
`endif
    output logic [clog2(DEPTH+1)-1:0]   count
);

    localparam int CW = clog2(DEPTH+1);

    logic [DEPTH-1:0][WIDTH-1:0] stg_data;
    logic [DEPTH-1:0]            stg_vld;
    logic [CW-1:0]               count_q, count_d;

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        logic [WIDTH-1:0] stg_in;
        logic             stg_in_vld;

        if (i == 0) begin : g_head
            assign stg_in     = d;
            assign stg_in_vld = d_valid;
        end else begin : g_body
            assign stg_in     = stg_data[i-1];
            assign stg_in_vld = stg_vld[i-1];
        end

        dreg_stage #(.WIDTH(WIDTH)) u_stage (
            .clk     (clk),
            .rstb    (rstb),
            .en      (en),
            .flush   (flush),
            .d       (stg_in),
            .d_valid (stg_in_vld),
            .q       (stg_data[i]),
            .q_valid (stg_vld[i])
        );
    end

    // Occupancy: one word may enter and one may leave per enabled edge. If the
    // last stage is valid the count is >= 1, so the subtraction cannot wrap,
    // and entering+leaving at DEPTH leaves the count unchanged.
    always_comb begin
        count_d = count_q;
        if (flush)
            count_d = '0;
        else if (en)
            count_d = count_q + CW'(d_valid) - CW'(stg_vld[DEPTH-1]);
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) count_q <= '0;
        else       count_q <= count_d;
    end

    assign q       = stg_data[DEPTH-1];
    assign q_valid = stg_vld[DEPTH-1];
    assign count   = count_q;

`ifdef DREG_PIPELINE_TAPS_EN
    // Packed array flattens with stage 0 in the low WIDTH bits.
    assign taps      = stg_data;
    assign tap_valid = stg_vld;
`endif

endmodule

// File: tb/tb_dreg_pipeline.sv
// tb_dreg_pipeline -- directed self-checking bench for dreg_pipeline
// (WIDTH=8, DEPTH=4). Inputs change 1 time unit after a rising edge and
// outputs are checked at that same point, well away from the next edge.
module tb_dreg_pipeline;

    logic        clk;
    logic        rstb;
    logic        en;
    logic        flush;
    logic [7:0]  d;
    logic        d_valid;
    logic [7:0]  q;
    logic        q_valid;
    logic [2:0]  count;
`ifdef DREG_PIPELINE_TAPS_EN
    logic [31:0] taps;
    logic [3:0]  tap_valid;
`endif

    int ntests = 0;
    int nfail  = 0;

    dreg_pipeline #(.WIDTH(8), .DEPTH(4)) dut (
        .clk       (clk),
        .rstb      (rstb),
        .en        (en),
        .flush     (flush),
        .d         (d),
        .d_valid   (d_valid),
        .q         (q),
        .q_valid   (q_valid),
`ifdef DREG_PIPELINE_TAPS_EN
        .taps      (taps),
        .tap_valid (tap_valid),
`endif
        .count     (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Apply one set of inputs across one rising edge.
    task automatic cyc(input logic e, input logic f, input logic [7:0] dd, input logic dv);
        en = e; flush = f; d = dd; d_valid = dv;
        @(posedge clk);
        #1;
    endtask

    task automatic chk3(input string tag, input logic [7:0] eq, input logic eqv, input logic [2:0] ecnt);
        chk({tag, ".q"},       q,       eq);
        chk({tag, ".q_valid"}, q_valid, eqv);
        chk({tag, ".count"},   count,   ecnt);
    endtask

    initial begin
        rstb = 1'b0; en = 1'b0; flush = 1'b0; d = '0; d_valid = 1'b0;
        #1;
        chk3("reset", 8'h00, 1'b0, 3'd0);
        @(negedge clk);
        rstb = 1'b1;

        // First update only on an enabled edge after reset release.
        cyc(1'b0, 1'b0, 8'h77, 1'b1);
        chk3("post_rst_hold", 8'h00, 1'b0, 3'd0);

        // Latency: A5 then bubbles; q_valid exactly on 4th edge; count 1,1,1,1,0.
        cyc(1'b1, 1'b0, 8'hA5, 1'b1); chk3("lat1", 8'h00, 1'b0, 3'd1);
        cyc(1'b1, 1'b0, 8'h00, 1'b0); chk3("lat2", 8'h00, 1'b0, 3'd1);
        cyc(1'b1, 1'b0, 8'h00, 1'b0); chk3("lat3", 8'h00, 1'b0, 3'd1);
        cyc(1'b1, 1'b0, 8'h00, 1'b0); chk3("lat4", 8'hA5, 1'b1, 3'd1);
        cyc(1'b1, 1'b0, 8'h00, 1'b0); chk3("lat5", 8'h00, 1'b0, 3'd0);

        // Bubble data still shifts; empty pipe never underflows.
        cyc(1'b1, 1'b0, 8'h5A, 1'b0);
        cyc(1'b1, 1'b0, 8'h00, 1'b0);
        cyc(1'b1, 1'b0, 8'h00, 1'b0);
        cyc(1'b1, 1'b0, 8'h00, 1'b0); chk3("bubble", 8'h5A, 1'b0, 3'd0);

        // Stall: 11, 22, three disabled edges, then resume.
        cyc(1'b1, 1'b0, 8'h11, 1'b1);
        cyc(1'b1, 1'b0, 8'h22, 1'b1); chk3("stall_pre", 8'h00, 1'b0, 3'd2);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 1'b0, 8'hEE, 1'b1); chk3("stall", 8'h00, 1'b0, 3'd2);
        end
        cyc(1'b1, 1'b0, 8'h00, 1'b0); chk3("resume3", 8'h00, 1'b0, 3'd2);
        cyc(1'b1, 1'b0, 8'h00, 1'b0); chk3("resume4", 8'h11, 1'b1, 3'd2);
        cyc(1'b1, 1'b0, 8'h00, 1'b0); chk3("resume5", 8'h22, 1'b1, 3'd1);
        cyc(1'b1, 1'b0, 8'h00, 1'b0); chk3("resume6", 8'h00, 1'b0, 3'd0);

        // Full throughput 01..08: count saturates at 4, q = i-3 from edge 4.
        for (int i = 1; i <= 8; i++) begin
            cyc(1'b1, 1'b0, 8'(i), 1'b1);
            if (i < 4) chk3("stream", 8'h00, 1'b0, 3'(i));
            else       chk3("stream", 8'(i - 3), 1'b1, 3'd4);
        end

        // Flush with en=1 and a valid FF present: FF discarded, data kept.
        cyc(1'b1, 1'b1, 8'hFF, 1'b1); chk3("flush", 8'h05, 1'b0, 3'd0);
        cyc(1'b1, 1'b0, 8'h00, 1'b0); chk3("flush_d1", 8'h06, 1'b0, 3'd0);
        cyc(1'b1, 1'b0, 8'h00, 1'b0); chk3("flush_d2", 8'h07, 1'b0, 3'd0);
        cyc(1'b1, 1'b0, 8'h00, 1'b0); chk3("flush_d3", 8'h08, 1'b0, 3'd0);
        cyc(1'b1, 1'b0, 8'h00, 1'b0); chk3("flush_d4", 8'h00, 1'b0, 3'd0);

        // Flush with en=0 still invalidates.
        cyc(1'b1, 1'b0, 8'hC3, 1'b1); chk3("fl_en0_load", 8'h00, 1'b0, 3'd1);
        cyc(1'b0, 1'b1, 8'h00, 1'b0); chk3("fl_en0", 8'h00, 1'b0, 3'd0);
        cyc(1'b1, 1'b0, 8'h00, 1'b0);
        cyc(1'b1, 1'b0, 8'h00, 1'b0);
        cyc(1'b1, 1'b0, 8'h00, 1'b0); chk3("fl_en0_out", 8'hC3, 1'b0, 3'd0);

`ifdef DREG_PIPELINE_TAPS_EN
        cyc(1'b1, 1'b0, 8'h01, 1'b1);
        cyc(1'b1, 1'b0, 8'h02, 1'b1);
        cyc(1'b1, 1'b0, 8'h03, 1'b1);
        cyc(1'b1, 1'b0, 8'h04, 1'b1);
        chk("taps",      taps,      32'h0102_0304);
        chk("tap_valid", tap_valid, 32'hF);
`endif

        // Mid-stream async reset with count=3.
        cyc(1'b1, 1'b0, 8'h31, 1'b1);
        cyc(1'b1, 1'b0, 8'h32, 1'b1);
        cyc(1'b1, 1'b0, 8'h33, 1'b1);
        cyc(1'b1, 1'b0, 8'h34, 1'b1);
        cyc(1'b1, 1'b0, 8'h00, 1'b0); chk3("pre_rst", 8'h32, 1'b1, 3'd3);
        #2 rstb = 1'b0;
        #1 chk3("async_rst", 8'h00, 1'b0, 3'd0);
        @(negedge clk);
        rstb = 1'b1;
        cyc(1'b1, 1'b0, 8'h00, 1'b0); chk3("after_rst", 8'h00, 1'b0, 3'd0);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
